// File: rtl/xmm_pkg.sv
// ---------------------------------------------------------------------------
// xmm_pkg
// Shared definitions for the XMM fixed-point arithmetic unit:
//   - op_code encodings (XMM_OP_ADD .. XMM_OP_NEG)
//   - default fraction width and the signed saturation limits
//   - FSM state encoding for xmm_fixed_point_unit
//   - helpers for magnitude and for signing/saturating an unsigned magnitude
// ---------------------------------------------------------------------------
package xmm_pkg;

  localparam int XMM_WIDTH     = 64;
  localparam int XMM_FRAC_BITS = 15;

  localparam logic [2:0] XMM_OP_ADD = 3'b000;
  localparam logic [2:0] XMM_OP_SUB = 3'b001;
  localparam logic [2:0] XMM_OP_MUL = 3'b010;
  localparam logic [2:0] XMM_OP_DIV = 3'b011;
  localparam logic [2:0] XMM_OP_MIN = 3'b100;
  localparam logic [2:0] XMM_OP_MAX = 3'b101;
  localparam logic [2:0] XMM_OP_ABS = 3'b110;
  localparam logic [2:0] XMM_OP_NEG = 3'b111;

  localparam logic [63:0] XMM_SMAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] XMM_SMIN = 64'h8000_0000_0000_0000;

  localparam logic [1:0] XMM_ST_IDLE = 2'd0;
  localparam logic [1:0] XMM_ST_MUL  = 2'd1;
  localparam logic [1:0] XMM_ST_DIV  = 2'd2;
  localparam logic [1:0] XMM_ST_DONE = 2'd3;

  // Unsigned magnitude of a signed word. |SMIN| = 2^63 still fits in an
  // unsigned 64-bit value, so no extra bit is needed at this point.
  function automatic logic [63:0] xmm_abs(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

  // Applies a sign to a 65-bit magnitude and saturates to the signed range.
  // Returns {sat, result}. Callers fold any discarded high bits into mag[64]
  // so that they force saturation.
  function automatic logic [64:0] xmm_sign_sat(input logic [64:0] mag, input logic neg);
    logic [64:0] r;
    if (neg) begin
      if (mag > {1'b0, XMM_SMIN}) r = {1'b1, XMM_SMIN};
      else                        r = {1'b0, ~mag[63:0] + 64'd1};
    end else begin
      if (mag > {1'b0, XMM_SMAX}) r = {1'b1, XMM_SMAX};
      else                        r = {1'b0, mag[63:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/xmm_iter_divider.sv
// ---------------------------------------------------------------------------
// xmm_iter_divider
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// The first quotient bit is produced on the start edge itself, so a division
// of a DIVIDEND_W-bit value takes DIVIDEND_W edges starting with i_start.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_start      load operands and perform the first iteration
//   i_dividend   unsigned dividend (DIVIDEND_W bits)
//   i_divisor    unsigned divisor, must be non-zero (DIVISOR_W bits)
//   o_busy       iterations still outstanding
//   o_done       one-cycle pulse, o_quot is final
//   o_quot       quotient (DIVIDEND_W bits)
// ---------------------------------------------------------------------------
module xmm_iter_divider #(
  parameter int DIVIDEND_W = 79,
  parameter int DIVISOR_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DIVIDEND_W-1:0] i_dividend,
  input  logic [DIVISOR_W-1:0]  i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DIVIDEND_W-1:0] o_quot
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_div;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;

  logic [DIVISOR_W-1:0]  w_rem_src;
  logic [DIVIDEND_W-1:0] w_quo_src;
  logic [DIVISOR_W-1:0]  w_div_src;
  logic [DIVISOR_W:0]    w_shift;
  logic                  w_fits;
  logic [DIVISOR_W-1:0]  w_trial;
  logic [DIVISOR_W-1:0]  w_rem_next;
  logic [DIVIDEND_W-1:0] w_quo_next;

  // One restoring step. The dividend is shifted out of the quotient register
  // MSB-first while quotient bits are shifted in at the bottom. On the start
  // edge the step works directly on the incoming operands.
  always_comb begin
    w_rem_src  = i_start ? '0 : r_rem;
    w_quo_src  = i_start ? i_dividend : r_quo;
    w_div_src  = i_start ? i_divisor : r_div;
    w_shift    = {w_rem_src, w_quo_src[DIVIDEND_W-1]};
    w_fits     = (w_shift >= {1'b0, w_div_src});
    // When the divisor fits the true difference is below 2^DIVISOR_W, so the
    // truncated subtraction is exact.
    w_trial    = w_shift[DIVISOR_W-1:0] - w_div_src;
    w_rem_next = w_fits ? w_trial : w_shift[DIVISOR_W-1:0];
    w_quo_next = {w_quo_src[DIVIDEND_W-2:0], w_fits};
  end

  // Iteration sequencing and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_next;
        r_quo  <= w_quo_next;
        r_div  <= i_divisor;
        r_cnt  <= CNT_W'(1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        if (r_cnt == LAST) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quot = r_quo;

endmodule

// File: rtl/xmm_fixed_point_unit.sv
// ---------------------------------------------------------------------------
// xmm_fixed_point_unit
// Sequential signed fixed-point arithmetic unit for the XMM datapath.
// add/sub/min/max/abs/neg finish one edge after acceptance; mul is a 64-step
// shift-add, div a (64+FRAC_BITS)-step restoring division on magnitudes.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op_valid / op_ready   operation handshake (ready only while idle)
//   op_code, op_a, op_b   operation and signed fixed-point operands
//   res_valid / res_ready result handshake
//   fpu_res, res_sat      result word and saturation flag
// ---------------------------------------------------------------------------
module xmm_fixed_point_unit
  import xmm_pkg::*;
#(
  parameter int FRAC_BITS = XMM_FRAC_BITS,
  parameter int WIDTH     = XMM_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] fpu_res,
  output logic             res_sat
);

  localparam int QW = WIDTH + FRAC_BITS;

  logic [1:0]       r_state;
  logic             r_start;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [127:0]     r_prod;
  logic             r_neg;
  logic [WIDTH-1:0] r_res;
  logic             r_sat;

  logic             w_accept;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [64:0]      w_sum;
  logic [64:0]      w_diff;
  logic [64:0]      w_alu;
  logic [WIDTH-1:0] w_divz;
  logic [64:0]      w_mul_step;
  logic [127:0]     w_prod_next;
  logic [64:0]      w_mul_res;
  logic [64:0]      w_div_res;
  logic             w_div_start;
  logic             w_div_busy;
  logic             w_div_done;
  logic [QW-1:0]    w_quot;

  // r_start marks the cycle after acceptance; operands are latched first and
  // dispatched from the registers, which keeps op_ready low during that cycle.
  assign op_ready  = (r_state == XMM_ST_IDLE) && !r_start && !w_div_busy;
  assign w_accept  = op_valid && op_ready;
  assign res_valid = (r_state == XMM_ST_DONE);
  assign fpu_res   = r_res;
  assign res_sat   = r_sat;

  assign w_mag_a     = xmm_abs(r_a);
  assign w_mag_b     = xmm_abs(r_b);
  assign w_div_start = r_start && (r_state == XMM_ST_IDLE) && (r_op == XMM_OP_DIV) && (r_b != '0);

  // Single-cycle operations, producing {sat, result}. Overflow of add/sub is
  // detected by the two top bits of the sign-extended 65-bit sum disagreeing.
  always_comb begin
    w_sum  = {r_a[63], r_a} + {r_b[63], r_b};
    w_diff = {r_a[63], r_a} - {r_b[63], r_b};
    w_alu  = '0;
    case (r_op)
      XMM_OP_ADD: w_alu = (w_sum[64] != w_sum[63])
                          ? {1'b1, (w_sum[64] ? XMM_SMIN : XMM_SMAX)} : {1'b0, w_sum[63:0]};
      XMM_OP_SUB: w_alu = (w_diff[64] != w_diff[63])
                          ? {1'b1, (w_diff[64] ? XMM_SMIN : XMM_SMAX)} : {1'b0, w_diff[63:0]};
      XMM_OP_MIN: w_alu = {1'b0, (($signed(r_a) < $signed(r_b)) ? r_a : r_b)};
      XMM_OP_MAX: w_alu = {1'b0, (($signed(r_a) > $signed(r_b)) ? r_a : r_b)};
      XMM_OP_ABS: w_alu = (r_a == XMM_SMIN) ? {1'b1, XMM_SMAX} : {1'b0, w_mag_a};
      XMM_OP_NEG: w_alu = (r_a == XMM_SMIN) ? {1'b1, XMM_SMAX} : {1'b0, ~r_a + 64'd1};
      default:    w_alu = '0;
    endcase
    w_divz = r_a[63] ? XMM_SMIN : ((r_a == '0) ? '0 : XMM_SMAX);
  end

  // Right-shifting shift-add multiplier: the multiplier starts in the low half
  // of r_prod and is consumed LSB-first while partial sums enter at the top.
  // The final result is taken from the last step's output so the DONE edge
  // coincides with the 64th iteration.
  always_comb begin
    w_mul_step  = {1'b0, r_prod[127:64]} + (r_prod[0] ? {1'b0, r_mcand} : 65'd0);
    w_prod_next = {w_mul_step, r_prod[63:1]};
    w_mul_res   = xmm_sign_sat({|w_prod_next[127:FRAC_BITS+64], w_prod_next[FRAC_BITS+63:FRAC_BITS]}, r_neg);
    w_div_res   = xmm_sign_sat({|w_quot[QW-1:64], w_quot[63:0]}, r_neg);
  end

  xmm_iter_divider #(
    .DIVIDEND_W (QW),
    .DIVISOR_W  (WIDTH)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_div_start),
    .i_dividend ({w_mag_a, {FRAC_BITS{1'b0}}}),
    .i_divisor  (w_mag_b),
    .o_busy     (w_div_busy),
    .o_done     (w_div_done),
    .o_quot     (w_quot)
  );

  // Control FSM: operand capture, dispatch, multiply iterations, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= XMM_ST_IDLE;
      r_start <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_neg   <= 1'b0;
      r_res   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_op <= op_code;
        r_a  <= op_a;
        r_b  <= op_b;
      end
      case (r_state)
        XMM_ST_IDLE: begin
          if (r_start) begin
            r_neg <= r_a[63] ^ r_b[63];
            case (r_op)
              XMM_OP_MUL: begin
                r_state <= XMM_ST_MUL;
                r_cnt   <= '0;
                r_mcand <= w_mag_a;
                r_prod  <= {64'd0, w_mag_b};
              end
              XMM_OP_DIV: begin
                if (r_b == '0) begin
                  r_state <= XMM_ST_DONE;
                  r_res   <= w_divz;
                  r_sat   <= 1'b1;
                end else begin
                  r_state <= XMM_ST_DIV;
                end
              end
              default: begin
                r_state <= XMM_ST_DONE;
                r_res   <= w_alu[63:0];
                r_sat   <= w_alu[64];
              end
            endcase
          end
        end
        XMM_ST_MUL: begin
          r_prod <= w_prod_next;
          r_cnt  <= r_cnt + 6'd1;
          if (r_cnt == 6'd63) begin
            r_state <= XMM_ST_DONE;
            r_res   <= w_mul_res[63:0];
            r_sat   <= w_mul_res[64];
          end
        end
        XMM_ST_DIV: begin
          if (w_div_done) begin
            r_state <= XMM_ST_DONE;
            r_res   <= w_div_res[63:0];
            r_sat   <= w_div_res[64];
          end
        end
        XMM_ST_DONE: begin
          if (res_ready) r_state <= XMM_ST_IDLE;
        end
        default: r_state <= XMM_ST_IDLE;
      endcase
    end
  end

endmodule
